led_sequencer: RTL and testbench

Parametrised LED pattern generator for board bring-up and status display. It drives N_LEDS outputs and steps through one of four selectable patterns (shift, bounce, fill, blink) at a rate set by a clock prescaler. It also supports pause and manual single-step. Instantiated at the top level of example designs, fed directly by board switches and buttons.

---
 rtl/led_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_led_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_sequencer.sv
// -----------------------------------------------------------------------------
// led_sequencer
// LED pattern generator for board bring-up and status display. Steps through
// one of four patterns (shift, bounce, fill, blink) either on a free-running
// prescaler or on manual step requests while paused.
//
// Parameters:
//   N_LEDS   number of LED outputs (2..32)
//   TICK_DIV clock cycles per pattern step while free-running (>= 1)
//   CNT_W    prescaler width, 2**CNT_W > TICK_DIV
//   PWM_W    duty-cycle width (only with LED_SEQUENCER_PWM_EN)
//
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   i_mode   pattern select: 0 SHIFT, 1 BOUNCE, 2 FILL, 3 BLINK
//   i_run    1 = free-run on prescaler, 0 = paused / manual stepping
//   i_step   manual step request, rising edge honoured only while paused
//   i_duty   PWM brightness (only with LED_SEQUENCER_PWM_EN)
//   o_leds   registered LED drive, active-high
//   o_tick   one-cycle pulse alongside every pattern step
//   o_wrap   one-cycle pulse on the step that returns to the start state
//
// Optional feature macro: LED_SEQUENCER_PWM_EN adds brightness gating of
// o_leds from a free-running PWM counter compared against i_duty.
// -----------------------------------------------------------------------------
// state (mode_q) | meaning
// ---------------+---------------------------------------------------------
// MODE_SHIFT     | single lit LED walks 0..N-1, wraps to 0
// MODE_BOUNCE    | single lit LED walks up to N-1 and back down to 0
// MODE_FILL      | thermometer fill 0..N lit, then empty
// MODE_BLINK     | all LEDs toggle between off and on
// -----------------------------------------------------------------------------
module led_sequencer #(
    parameter int N_LEDS   = 4,
    parameter int TICK_DIV = 2600000,
    parameter int CNT_W    = 32
`ifdef LED_SEQUENCER_PWM_EN
    ,
    parameter int PWM_W    = 4
`endif
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [1:0]        i_mode,
    input  logic              i_run,
    input  logic              i_step,
`ifdef LED_SEQUENCER_PWM_EN
    input  logic [PWM_W-1:0]  i_duty,
`endif
    output logic [N_LEDS-1:0] o_leds,
    output logic              o_tick,
    output logic              o_wrap
);

    localparam int PW = $clog2(N_LEDS + 1);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TICK_DIV - 1);
    localparam logic [PW-1:0] POS_LAST = PW'(N_LEDS - 1);
    localparam logic [PW-1:0] POS_FULL = PW'(N_LEDS);
    localparam logic [PW-1:0] POS_ONE  = PW'(1);

    typedef enum logic [1:0] {
        MODE_SHIFT  = 2'd0,
        MODE_BOUNCE = 2'd1,
        MODE_FILL   = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_t;

    mode_t             mode_q;
    logic [PW-1:0]     pos, pos_d;
    logic              dir_down, dir_down_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              step_q;
    logic              mode_chg;
    logic              adv;
    logic              tick_d, wrap_d;
    logic [N_LEDS-1:0] pat_d;
    logic [N_LEDS-1:0] leds_d;

`ifdef LED_SEQUENCER_PWM_EN
    logic [PWM_W-1:0]  pwm_cnt;
`endif

    // State register: pattern position, prescaler, edge detector and the
    // registered outputs all move together so o_leds/o_tick/o_wrap align.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mode_q   <= MODE_SHIFT;
            pos      <= '0;
            dir_down <= 1'b0;
            cnt      <= RELOAD;
            step_q   <= 1'b0;
            o_leds   <= N_LEDS'(1);
            o_tick   <= 1'b0;
            o_wrap   <= 1'b0;
        end else begin
            mode_q   <= mode_t'(i_mode);
            pos      <= pos_d;
            dir_down <= dir_down_d;
            cnt      <= cnt_d;
            step_q   <= i_step;
            o_leds   <= leds_d;
            o_tick   <= tick_d;
            o_wrap   <= wrap_d;
        end
    end

`ifdef LED_SEQUENCER_PWM_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end
`endif

    // Next-state logic: prescaler / step detection and pattern advance.
    always_comb begin
        mode_chg   = (i_mode != mode_q);
        adv        = 1'b0;
        cnt_d      = RELOAD;
        pos_d      = pos;
        dir_down_d = dir_down;
        tick_d     = 1'b0;
        wrap_d     = 1'b0;

        if (i_run) begin
            if (cnt == '0) begin
                adv = 1'b1;
            end else begin
                cnt_d = cnt - 1'b1;
            end
        end else begin
            adv = i_step & ~step_q;
        end

        // A mode change restarts the new pattern and swallows any step
        // that happened to land on the same cycle.
        if (mode_chg) begin
            pos_d      = '0;
            dir_down_d = 1'b0;
            cnt_d      = RELOAD;
        end else if (adv) begin
            tick_d = 1'b1;
            case (mode_q)
                MODE_SHIFT: begin
                    if (pos == POS_LAST) begin
                        pos_d  = '0;
                        wrap_d = 1'b1;
                    end else begin
                        pos_d = pos + 1'b1;
                    end
                end
                MODE_BOUNCE: begin
                    // Turn around at either end before moving so the ends
                    // are not repeated.
                    if ((!dir_down && pos != POS_LAST) || (dir_down && pos == '0)) begin
                        pos_d = pos + 1'b1;
                    end else begin
                        pos_d = pos - 1'b1;
                    end
                    if (pos_d == POS_LAST) begin
                        dir_down_d = 1'b1;
                    end else if (pos_d == '0) begin
                        dir_down_d = 1'b0;
                        wrap_d     = 1'b1;
                    end
                end
                MODE_FILL: begin
                    if (pos == POS_FULL) begin
                        pos_d  = '0;
                        wrap_d = 1'b1;
                    end else begin
                        pos_d = pos + 1'b1;
                    end
                end
                MODE_BLINK: begin
                    if (pos == POS_ONE) begin
                        pos_d  = '0;
                        wrap_d = 1'b1;
                    end else begin
                        pos_d = POS_ONE;
                    end
                end
                default: begin
                    pos_d = '0;
                end
            endcase
        end
    end

    // Output logic: pattern for the next position. i_mode is used rather
    // than mode_q so a mode change shows the new start pattern at once;
    // without a change the two are equal.
    always_comb begin
        pat_d = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            case (mode_t'(i_mode))
                MODE_SHIFT,
                MODE_BOUNCE: pat_d[i] = (pos_d == PW'(i));
                MODE_FILL:   pat_d[i] = (PW'(i) < pos_d);
                MODE_BLINK:  pat_d[i] = (pos_d == POS_ONE);
                default:     pat_d[i] = 1'b0;
            endcase
        end
`ifdef LED_SEQUENCER_PWM_EN
        leds_d = pat_d & {N_LEDS{pwm_cnt < i_duty}};
`else
        leds_d = pat_d;
`endif
    end

endmodule

// File: tb/tb_led_sequencer.sv
module tb_led_sequencer;

    localparam int N  = 4;
    localparam int TD = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] mode  = 2'd0;
    logic       run   = 1'b1;
    logic       step  = 1'b0;
    logic [3:0] duty  = 4'hF;
    logic [3:0] leds;
    logic       tick;
    logic       wrap;

    always #5 clk = ~clk;

    led_sequencer #(.N_LEDS(N), .TICK_DIV(TD), .CNT_W(8)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_mode  (mode),
        .i_run   (run),
        .i_step  (step),
`ifdef LED_SEQUENCER_PWM_EN
        .i_duty  (duty),
`endif
        .o_leds  (leds),
        .o_tick  (tick),
        .o_wrap  (wrap)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference pattern tables, one entry per step from the start state.
    logic [3:0] tab_shift  [4] = '{4'h1, 4'h2, 4'h4, 4'h8};
    logic [3:0] tab_bounce [6] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2};
    logic [3:0] tab_fill   [5] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF};
    logic [3:0] tab_blink  [2] = '{4'h0, 4'hF};

    function automatic int seq_len(input logic [1:0] md);
        case (md)
            2'd0:    return 4;
            2'd1:    return 6;
            2'd2:    return 5;
            default: return 2;
        endcase
    endfunction

    function automatic logic [3:0] seq_val(input logic [1:0] md, input int k);
        case (md)
            2'd0:    return tab_shift[k];
            2'd1:    return tab_bounce[k];
            2'd2:    return tab_fill[k];
            default: return tab_blink[k];
        endcase
    endfunction

    // Model state
    int         m_cnt   = TD - 1;
    int         m_idx   = 0;
    int         m_pwm   = 0;
    logic [1:0] m_mode  = 2'd0;
    logic       m_stepq = 1'b0;
    logic [3:0] m_pat   = 4'h1;
    logic [5:0] sb_q [$];
    logic       m_adv, m_gate, e_tick, e_wrap;
    logic [3:0] e_leds;
    int         n_ticks = 0;

    always @(negedge rst_n) begin
        m_cnt   = TD - 1;
        m_idx   = 0;
        m_pwm   = 0;
        m_mode  = 2'd0;
        m_stepq = 1'b0;
        m_pat   = 4'h1;
        sb_q.delete();
    end

    // Scoreboard producer: predicts the registered outputs for each edge.
    always @(posedge clk) begin
        if (rst_n) begin
            e_tick = 1'b0;
            e_wrap = 1'b0;
`ifdef LED_SEQUENCER_PWM_EN
            m_gate = (m_pwm < int'(duty));
`else
            m_gate = 1'b1;
`endif
            if (mode != m_mode) begin
                m_mode = mode;
                m_idx  = 0;
                m_cnt  = TD - 1;
                m_pat  = seq_val(mode, 0);
            end else begin
                if (run) begin
                    m_adv = (m_cnt == 0);
                    m_cnt = m_adv ? TD - 1 : m_cnt - 1;
                end else begin
                    m_adv = step && !m_stepq;
                    m_cnt = TD - 1;
                end
                if (m_adv) begin
                    m_idx  = (m_idx + 1) % seq_len(m_mode);
                    m_pat  = seq_val(m_mode, m_idx);
                    e_tick = 1'b1;
                    e_wrap = (m_idx == 0);
                end
            end
            m_stepq = step;
            m_pwm   = (m_pwm + 1) % 16;
            e_leds  = m_gate ? m_pat : 4'h0;
            sb_q.push_back({e_leds, e_tick, e_wrap});
        end
    end

    // Scoreboard consumer: compare away from the active edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            check("cycle_out", {26'd0, leds, tick, wrap}, {26'd0, sb_q.pop_front()});
        end
        if (tick) n_ticks++;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    int  base;
    int  lit;
    bit  found;

    initial begin
        repeat (3) @(negedge clk);
        check("reset_leds", {28'd0, leds}, 32'h1);
        check("reset_tick", {31'd0, tick}, 32'h0);
        check("reset_wrap", {31'd0, wrap}, 32'h0);
        rst_n = 1'b1;

        repeat (24) @(negedge clk);   // SHIFT, free-run
        mode = 2'd1;
        repeat (30) @(negedge clk);   // BOUNCE
        mode = 2'd2;
        repeat (30) @(negedge clk);   // FILL
        mode = 2'd3;
        repeat (20) @(negedge clk);   // BLINK

        // Manual stepping
        mode = 2'd0;
        run  = 1'b0;
        repeat (3) @(negedge clk);
        base = n_ticks;
        for (int p = 0; p < 3; p++) begin
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            repeat (3) @(negedge clk);
        end
        repeat (2) @(negedge clk);
        check("step_pulses", n_ticks - base, 3);

        base = n_ticks;
        step = 1'b1;
        repeat (10) @(negedge clk);
        step = 1'b0;
        repeat (3) @(negedge clk);
        check("step_held", n_ticks - base, 1);

        // Step toggling while free-running must not add steps
        base = n_ticks;
        run  = 1'b1;
        for (int c = 0; c < 16; c++) begin
            step = ~step;
            @(negedge clk);
        end
        step = 1'b0;
        @(negedge clk);
        check("run_ignores_step", n_ticks - base, 4);

        // Mode change landing on the terminal count
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (m_cnt == 0) found = 1'b1;
        end
        check("reach_cnt0", {31'd0, found}, 32'h1);
        mode = 2'd2;
        @(negedge clk);
        check("chg_leds", {28'd0, leds}, 32'h0);
        check("chg_tick", {31'd0, tick}, 32'h0);
        repeat (3) @(negedge clk);
        check("chg_no_early", {31'd0, tick}, 32'h0);
        @(negedge clk);
        check("chg_next_step", {31'd0, tick}, 32'h1);

        // Asynchronous reset mid-pattern
        mode  = 2'd0;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (m_mode == 2'd0 && m_pat == 4'h4) found = 1'b1;
        end
        check("reach_0100", {31'd0, found}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_leds", {28'd0, leds}, 32'h1);
        check("async_rst_tick", {31'd0, tick}, 32'h0);
        check("async_rst_wrap", {31'd0, wrap}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);

`ifdef LED_SEQUENCER_PWM_EN
        run  = 1'b0;
        duty = 4'd4;
        repeat (2) @(negedge clk);
        lit = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (leds != 4'h0) lit++;
        end
        check("pwm_duty4", lit, 4);
        duty = 4'd0;
        repeat (2) @(negedge clk);
        lit = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (leds != 4'h0) lit++;
        end
        check("pwm_duty0", lit, 0);
        duty = 4'hF;
`endif

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
